// File: rtl/sevseg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner sharing one hex decoder, with
// per-slot blanking gap and frame-aligned value commit. Define LEADING_ZERO_BLANK_EN
// to suppress leading zero digits.
module sevseg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  ca,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_val_q, disp_val_d;
    logic [3:0]       disp_dp_q, disp_dp_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       ca_q, ca_d;
    logic             dp_q, dp_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_last;
    logic             wrap;
    logic             suppress;
    logic             visible;
    logic [3:0]       nibble;

    // Segment order {g,f,e,d,c,b,a}, active-low for a common-anode display.
    function automatic logic [6:0] hex2sevseg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_last  = (slot_cnt_q == CNT_LAST);
        wrap       = enable && slot_last && (idx_q == 2'd3);
        slot_cnt_d = slot_cnt_q;
        idx_d      = idx_q;
        if (enable) begin
            if (slot_last) begin
                slot_cnt_d = '0;
                idx_d      = idx_q + 2'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + CNT_W'(1);
            end
        end
    end

    // A load landing on the wrap cycle bypasses the pending register entirely.
    always_comb begin
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (wrap) begin
            if (load) begin
                disp_val_d = value_in;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = value_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    suppress = (disp_val_q[15:4]  == 12'h000) && !disp_dp_q[1];
            2'd2:    suppress = (disp_val_q[15:8]  == 8'h00)   && !disp_dp_q[2];
            2'd3:    suppress = (disp_val_q[15:12] == 4'h0)    && !disp_dp_q[3];
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif
    end

    always_comb begin
        nibble       = disp_val_q[{idx_q, 2'b00} +: 4];
        visible      = enable && (32'(slot_cnt_q) >= 32'(BLANK_CYCLES)) && !suppress;
        an_d         = 4'b1111;
        ca_d         = 7'b1111111;
        dp_d         = 1'b1;
        digit_sel_d  = idx_q;
        frame_tick_d = wrap;
        if (visible) begin
            an_d = ~(4'b0001 << idx_q);
            ca_d = hex2sevseg(nibble);
            dp_d = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            idx_q        <= 2'd0;
            disp_val_q   <= 16'h0000;
            disp_dp_q    <= 4'b0000;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            pend_valid_q <= 1'b0;
            an_q         <= 4'b1111;
            ca_q         <= 7'b1111111;
            dp_q         <= 1'b1;
            digit_sel_q  <= 2'd0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign ca         = ca_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl: directed scenarios plus random loads and
// enables, compared every cycle against a scan-position reference model.
module tb_sevseg_scan_ctrl;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: a count of enabled cycles since reset fixes the slot and position.
    int          pos;
    logic [15:0] shownVal, pendVal;
    logic [3:0]  shownDp, pendDp;
    bit          pendValid;
    logic [3:0]  expAn;
    logic [6:0]  expCa;
    logic        expDp;
    logic [1:0]  expSel;
    logic        expTick;

    sevseg_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
        .enable(enable), .an(an), .ca(ca), .dp(dp), .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, required %0h at time %0t", tag, observed, expected, $time);
    endtask

    function automatic logic [6:0] segOf(input logic [3:0] h);
        logic [6:0] segs [16];
        segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return segs[h];
    endfunction

    task automatic modelReset();
        pos = 0; shownVal = 16'h0; shownDp = 4'h0; pendVal = 16'h0; pendDp = 4'h0; pendValid = 0;
        expAn = 4'hF; expCa = 7'h7F; expDp = 1'b1; expSel = 2'd0; expTick = 1'b0;
    endtask

    function automatic int curSlot();
        return (pos / RDIV) % 4;
    endfunction

    function automatic int curCnt();
        return pos % RDIV;
    endfunction

    task automatic modelStep();
        int slot = curSlot();
        int cnt  = curCnt();
        bit wrap = enable && (cnt == RDIV - 1) && (slot == 3);
        bit vis  = enable && (cnt >= BLANK);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot >= 1 && (shownVal >> (4 * slot)) == 16'h0 && shownDp[slot] == 1'b0) vis = 0;
`endif
        expAn   = vis ? ~(4'b0001 << slot) : 4'hF;
        expCa   = vis ? segOf(shownVal[slot*4 +: 4]) : 7'h7F;
        expDp   = vis ? ~shownDp[slot] : 1'b1;
        expSel  = 2'(slot);
        expTick = wrap;
        if (wrap) begin
            if (load) begin shownVal = value_in; shownDp = dp_in; end
            else if (pendValid) begin shownVal = pendVal; shownDp = pendDp; end
            pendValid = 0;
        end else if (load) begin
            pendVal = value_in; pendDp = dp_in; pendValid = 1;
        end
        if (enable) pos++;
    endtask

    task automatic compareAll();
        checkOutput("an", an, expAn);
        checkOutput("ca", ca, expCa);
        checkOutput("dp", dp, expDp);
        checkOutput("digit_sel", digit_sel, expSel);
        checkOutput("frame_tick", frame_tick, expTick);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit en);
        load = ld; value_in = v; dp_in = d; enable = en;
        tick();
        load = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model says the next edge samples the given slot/count.
    task automatic runUntil(input int slot, input int cnt);
        for (int i = 0; i < 4 * RDIV; i++) begin
            if (curSlot() == slot && curCnt() == cnt) return;
            tick();
        end
    endtask

    initial begin
        modelReset();
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_an", an, 4'b1111);
        checkOutput("reset_ca", ca, 7'b1111111);
        checkOutput("reset_dp", dp, 1'b1);
        checkOutput("reset_sel", digit_sel, 2'd0);
        checkOutput("reset_tick", frame_tick, 1'b0);
        enable = 1'b1;
        #1 rst = 1'b0;

        tick();
        tick();
        tick();
        checkOutput("first_an", an, 4'b1110);
        checkOutput("first_ca", ca, 7'h40);
        runCycles(10);

        applyStimulus(1, 16'h1234, 4'b0100, 1);
        runCycles(70);

        runUntil(1, 3);
        applyStimulus(1, 16'hABCD, 4'b0000, 1);
        runCycles(70);

        runUntil(0, 2);
        applyStimulus(1, 16'h1111, 4'b0001, 1);
        runCycles(5);
        applyStimulus(1, 16'h2222, 4'b0010, 1);
        runUntil(3, RDIV - 1);
        tick();
        runUntil(3, RDIV - 1);
        applyStimulus(1, 16'h3333, 4'b1000, 1);
        runCycles(40);

        runUntil(2, 4);
        applyStimulus(0, 16'h0000, 4'b0000, 0);
        checkOutput("disable_blank_an", an, 4'b1111);
        runCycles(5);
        applyStimulus(0, 16'h0000, 4'b0000, 1);
        checkOutput("resume_an", an, 4'b1011);
        runCycles(40);

        runUntil(1, 3);
        applyStimulus(1, 16'h5555, 4'b1111, 1);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst_an", an, 4'b1111);
        checkOutput("async_rst_ca", ca, 7'b1111111);
        checkOutput("async_rst_dp", dp, 1'b1);
        checkOutput("async_rst_sel", digit_sel, 2'd0);
        #1 rst = 1'b0;
        runCycles(70);

        applyStimulus(1, 16'h0042, 4'b0000, 1);
        runUntil(3, RDIV - 1);
        tick();
        runCycles(40);

        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom),
                          $urandom_range(0, 9) != 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_ctrl.md
Name: sevseg_scan_ctrl

Overview:
- Time-multiplexes a single internal hex2sevseg decoder across a 4-digit common-anode seven-segment display.
- Holds a 16-bit hex value, steps a digit index with a refresh divider, and drives active-low anodes.
- Inserts a blanking gap between digits to suppress ghosting.
- Commits new values only at frame boundaries so a frame never shows a mix of old and new digits.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; 0 = no gap.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- value_in  in  16  hex value; nibble k goes to digit k (digit 0 = value_in[3:0])
- dp_in  in  4  decimal-point enables, bit k for digit k, active-high
- load  in  1  capture value_in/dp_in on this rising edge
- enable  in  1  1 = scan; 0 = freeze scan and blank display
- an  out  4  anodes, active-low one-hot
- ca  out  7  cathodes as produced by hex2sevseg; blank = 7'b1111111
- dp  out  1  decimal point cathode, active-low
- digit_sel  out  2  index of the digit currently in its slot
- frame_tick  out  1  one-cycle pulse on the slot 3 -> 0 wrap

Behaviour:
- Reset (async, immediate, no clock needed):
  - disp_val=16'h0000, disp_dp=0, pending cleared, slot_cnt=0, idx=0
  - an=4'b1111, ca=7'b1111111, dp=1, digit_sel=0, frame_tick=0
- Slot counter, when enable=1:
  - slot_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: slot_cnt->0 and idx->idx+1 mod 4.
  - When enable=0: slot_cnt and idx hold.
- Load:
  - load=1 writes value_in/dp_in into a pending register and sets pending_valid.
  - A later load before commit overwrites the pending contents; last load wins.
  - Loads are accepted regardless of enable.
- Commit (wrap cycle, idx 3->0):
  - If load=1 on that cycle, value_in/dp_in go straight to disp_val/disp_dp.
  - Otherwise, if pending_valid, the pending contents go to disp_val/disp_dp.
  - pending_valid clears in either case.
  - frame_tick=1 for exactly that cycle.
- Outputs, all registered, 1-cycle latency from slot_cnt/idx:
  - visible = enable && slot_cnt >= BLANK_CYCLES.
  - If visible: an = ~(4'b0001 << idx), ca = hex2sevseg(disp_val nibble idx), dp = ~disp_dp[idx].
  - If not visible: an=4'b1111, ca=7'b1111111, dp=1.
  - digit_sel = idx, registered.
- Boundaries:
  - enable falling: display blanks on the next edge.
  - enable rising: scan resumes at the held idx/slot_cnt.
  - Reset mid-slot or with a load pending: the pending value is discarded.
- Frame period = 4*REFRESH_DIV cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k>=1) is suppressed when disp_val nibbles k..3 are all zero and disp_dp[k]=0.
  - A suppressed digit keeps an=1111, ca=7'b1111111, dp=1 for its whole slot.
  - Digit 0 is always shown; slot timing is unchanged.
- Undefined: all four digits are always shown.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- rst=1 held, no clock edges -> an=4'b1111, ca=7'b1111111, dp=1, frame_tick=0. Release with enable=1 -> first an=4'b1110 (ca=hex2sevseg(0)) after the 3rd rising edge, held for 6 cycles, then 2 blank cycles.
- load 16'h1234, dp_in=4'b0100 mid-frame -> old digits until the next frame_tick. Afterwards:
  - an 1110/1101/1011/0111 with ca = hex2sevseg(4)/(3)/(2)/(1)
  - dp=0 only during an=1011
  - period 32 cycles
- Load 16'hABCD while idx=1 -> digits 2 and 3 of the current frame still show the old value; the full new value appears from the next frame.
- Loads 16'h1111 then 16'h2222 in the same frame -> next frame shows 2222 only. A load of 16'h3333 on the wrap cycle -> that frame shows 3333.
- enable=0 at idx=2, slot_cnt=4 -> an=1111 the next edge and idx/slot_cnt frozen. After re-enable -> an=1011 for the remaining visible cycles of slot 2.
- Async rst pulse mid-slot between edges -> outputs blank immediately; a pending load is lost and the display shows 0000 after release. With LEADING_ZERO_BLANK_EN, value 16'h0042 -> an=1111 during the slots for digits 2 and 3.
